// File: rtl/seq_acc_4bit_pkg.sv
// Shared definitions for the 4-bit sequential frame accumulator.
//   DW       : operand / partial-sum width.
//   state_e  : frame controller states.
//   last_op  : true when the operand being accepted closes an n_ops frame.
package seq_acc_4bit_pkg;

  localparam int unsigned DW = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // op_cnt holds the number of operands already taken before this transfer.
  function automatic logic last_op(input logic [DW-1:0] op_cnt,
                                   input int unsigned   n_ops);
    return op_cnt == DW'(n_ops - 1);
  endfunction

endpackage

// File: rtl/seq_acc_4bit_adder4_comb.sv
// Purely combinational 4-bit ripple-carry adder.
//   a, b : 4-bit operands
//   cin  : carry in
//   s    : 4-bit sum
//   cout : carry out of bit 3
module adder4_comb
  import seq_acc_4bit_pkg::*;
(
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          cin,
  output logic [DW-1:0] s,
  output logic          cout
);

  logic [DW:0] c;

  always_comb begin
    s    = '0;
    c    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < DW; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[DW];
  end

endmodule

// File: rtl/seq_acc_4bit.sv
// Sequential accumulator: sums a frame of N_OPS unsigned 4-bit operands with
// a 4-bit add-with-carry datapath, counting carry-outs so the frame total is
// exact ({carry_cnt, sum}).
//   clk, rst       : clock, synchronous active-high reset
//   in_valid/ready : operand handshake, operand on in_data
//   out_valid/ready: result handshake
//   out_sum        : low 4 bits of the frame total
//   out_carry_cnt  : number of carry-outs during the frame
//   out_total      : {out_carry_cnt, out_sum}
module seq_acc_4bit
  import seq_acc_4bit_pkg::*;
#(
  parameter int unsigned N_OPS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [3:0]   out_sum,
  output logic [3:0]   out_carry_cnt,
  output logic [7:0]   out_total
);

  state_e        state_q, state_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] op_cnt_q, op_cnt_d;
  logic [DW-1:0] carry_cnt_q, carry_cnt_d;

  logic [DW-1:0] add_s;
  logic          add_c;
  logic          in_xfer;
  logic          out_xfer;

  adder4_comb u_add (
    .a    (acc_q),
    .b    (in_data),
    .cin  (1'b0),
    .s    (add_s),
    .cout (add_c)
  );

  // Handshake outputs depend on registered state only.
  always_comb begin
    in_ready  = (state_q != ST_DONE);
    out_valid = (state_q == ST_DONE);
  end

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    op_cnt_d    = op_cnt_q;
    carry_cnt_d = carry_cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_xfer) begin
          acc_d       = in_data;
          carry_cnt_d = '0;
          op_cnt_d    = DW'(1);
          state_d     = ST_ACC;
        end
      end
      ST_ACC: begin
        if (in_xfer) begin
          acc_d       = add_s;
          carry_cnt_d = carry_cnt_q + {{(DW-1){1'b0}}, add_c};
          op_cnt_d    = op_cnt_q + DW'(1);
          if (last_op(op_cnt_q, N_OPS)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_xfer) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      op_cnt_q    <= '0;
      carry_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      op_cnt_q    <= op_cnt_d;
      carry_cnt_q <= carry_cnt_d;
    end
  end

  always_comb begin
    out_sum       = acc_q;
    out_carry_cnt = carry_cnt_q;
    out_total     = {carry_cnt_q, acc_q};
  end

endmodule

// File: tb/tb_seq_acc_4bit.sv
module tb_seq_acc_4bit;

  localparam int NS0 = 4;
  localparam int NS1 = 3;
  localparam int NS2 = 15;

  logic       clk;
  logic       rst;
  logic       in_valid  [3];
  logic       in_ready  [3];
  logic [3:0] in_data   [3];
  logic       out_valid [3];
  logic       out_ready [3];
  logic [3:0] out_sum   [3];
  logic [3:0] out_cc    [3];
  logic [7:0] out_total [3];

  int errors = 0;
  int checks = 0;

  seq_acc_4bit #(.N_OPS(NS0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_sum(out_sum[0]), .out_carry_cnt(out_cc[0]), .out_total(out_total[0]));
  seq_acc_4bit #(.N_OPS(NS1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_sum(out_sum[1]), .out_carry_cnt(out_cc[1]), .out_total(out_total[1]));
  seq_acc_4bit #(.N_OPS(NS2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_sum(out_sum[2]), .out_carry_cnt(out_cc[2]), .out_total(out_total[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Frame model: a DUT either owes a result (pending) or is collecting
  // operands; the result is the plain integer sum of the frame.
  int nops    [3];
  bit started;
  bit m_pend  [3];
  int m_cnt   [3];
  int m_tot   [3];

  initial begin
    nops[0] = NS0; nops[1] = NS1; nops[2] = NS2;
    for (int i = 0; i < 3; i++) begin
      if (nops[i] < 2 || nops[i] > 15) $fatal(1, "unsupported N_OPS %0d", nops[i]);
      m_pend[i] = 1'b0; m_cnt[i] = 0; m_tot[i] = 0;
    end
    started = 1'b0;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_pend[i] = 1'b0; m_cnt[i] = 0; m_tot[i] = 0;
      end else if (started) begin
        if (m_pend[i]) begin
          if (out_ready[i]) m_pend[i] = 1'b0;
        end else if (in_valid[i]) begin
          m_tot[i] = (m_cnt[i] == 0) ? int'(in_data[i]) : m_tot[i] + int'(in_data[i]);
          m_cnt[i]++;
          if (m_cnt[i] == nops[i]) begin
            m_pend[i] = 1'b1;
            m_cnt[i]  = 0;
          end
        end
      end
    end
    if (rst) started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("model_in_ready[%0d]", i), int'(in_ready[i]), int'(!m_pend[i]));
        chk($sformatf("model_out_valid[%0d]", i), int'(out_valid[i]), int'(m_pend[i]));
        if (m_pend[i]) begin
          chk($sformatf("model_total[%0d]", i), int'(out_total[i]), m_tot[i]);
          chk($sformatf("model_sum[%0d]", i), int'(out_sum[i]), m_tot[i] % 16);
          chk($sformatf("model_cc[%0d]", i), int'(out_cc[i]), m_tot[i] / 16);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int idx, input logic [3:0] d, input int gap);
    logic r;
    int   k;
    in_valid[idx] = 1'b1;
    in_data[idx]  = d;
    for (k = 0; k < 50; k++) begin
      r = in_ready[idx];
      tick();
      if (r) break;
    end
    if (k == 50) chk("send_timeout", 0, 1);
    in_valid[idx] = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_result(input string name, input int idx, input int exp_total);
    int k;
    for (k = 0; k < 100; k++) begin
      if (out_valid[idx]) break;
      tick();
    end
    if (k == 100) chk({name, "_timeout"}, 0, 1);
    chk({name, "_total"}, int'(out_total[idx]), exp_total);
    chk({name, "_sum"}, int'(out_sum[idx]), exp_total % 16);
    chk({name, "_cc"}, int'(out_cc[idx]), exp_total / 16);
    if (out_ready[idx]) tick();
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0; in_data[i] = 4'd0; out_ready[i] = 1'b1;
    end
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("reset_in_ready", int'(in_ready[i]), 1);
      chk("reset_out_valid", int'(out_valid[i]), 0);
      chk("reset_total", int'(out_total[i]), 0);
    end

    // Basic frame: 3+5+7+9 = 24
    send(0, 4'd3, 0); send(0, 4'd5, 0); send(0, 4'd7, 0); send(0, 4'd9, 0);
    chk("t1_latency_valid", int'(out_valid[0]), 1);
    wait_result("t1", 0, 8'h18);
    chk("t1_back_idle_ready", int'(in_ready[0]), 1);
    chk("t1_back_idle_valid", int'(out_valid[0]), 0);

    // Max operands: 4*15 = 60
    send(0, 4'd15, 0); send(0, 4'd15, 0); send(0, 4'd15, 0); send(0, 4'd15, 0);
    wait_result("t2", 0, 8'h3C);

    // Backpressure with junk offered in DONE
    out_ready[0] = 1'b0;
    send(0, 4'd1, 0); send(0, 4'd2, 0); send(0, 4'd3, 0); send(0, 4'd4, 0);
    in_valid[0] = 1'b1; in_data[0] = 4'hA;
    for (int c = 0; c < 5; c++) begin
      chk("t3_bp_in_ready", int'(in_ready[0]), 0);
      chk("t3_bp_valid", int'(out_valid[0]), 1);
      chk("t3_bp_total", int'(out_total[0]), 8'h0A);
      tick();
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    tick();
    chk("t3_released", int'(out_valid[0]), 0);
    send(0, 4'd2, 0); send(0, 4'd2, 0); send(0, 4'd2, 0); send(0, 4'd2, 0);
    wait_result("t3_next", 0, 8'h08);

    // Input gaps, N_OPS=3: 1+2+4 = 7
    send(1, 4'd1, 2);
    chk("t4_no_early1", int'(out_valid[1]), 0);
    send(1, 4'd2, 2);
    chk("t4_no_early2", int'(out_valid[1]), 0);
    send(1, 4'd4, 0);
    wait_result("t4", 1, 8'h07);

    // Reset mid-frame
    send(0, 4'd9, 0); send(0, 4'd9, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_after_rst_valid", int'(out_valid[0]), 0);
    chk("t5_after_rst_ready", int'(in_ready[0]), 1);
    send(0, 4'd1, 0); send(0, 4'd1, 0); send(0, 4'd1, 0); send(0, 4'd1, 0);
    wait_result("t5", 0, 8'h04);

    // N_OPS=15, all 15: 225
    for (int i = 0; i < 15; i++) send(2, 4'd15, 0);
    wait_result("t6", 2, 8'hE1);

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
